prog_counter: RTL and testbench
===============================

# prog_counter

Parametrised programmable counter: generalisation of the basic free-running 8-bit counter. Adds configurable width, prescaled stepping, enable, synchronous clear/load, up/down direction, and three counting modes (free wrap, modulo-limit, one-shot) with terminal-count and done flags. It serves as the standard timebase/event-counter primitive for generated designs and as a richer DUT for the sequence-driven testbench flow.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRESCALE, 1, clk cycles per step while `en` high (≥1; 1 = step every enabled cycle)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  count enable; gates prescaler and stepping
- clr  in  1  synchronous clear
- load  in  1  synchronous load of `load_val`
- load_val  in  WIDTH  value for load
- dir  in  1  0 = up, 1 = down
- mode  in  2  0 WRAP, 1 MOD, 2 ONESHOT, 3 reserved (behaves as WRAP)
- limit  in  WIDTH  modulus/terminal for MOD and ONESHOT (sampled every cycle)
- count  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered, one cycle)
- done  out  1  one-shot complete (sticky)

## Operation
- Priority per edge: clr > load > step. clr: count=0, done=0, prescaler=0. load: count=load_val, done=0, prescaler=0 (load_val not range-checked).
- step = en && tick. Prescaler counts 0..PRESCALE-1 while en; tick when at PRESCALE-1, then returns to 0. en low holds prescaler value. PRESCALE=1: tick constant 1.
- Terminal T: up → MOD/ONESHOT: limit, WRAP: all-ones; down → 0.
- "At terminal" (up): count ≥ T; (down): count == 0.
- WRAP/MOD step: not at terminal → ±1. At terminal → wrap: up → 0; down → limit (MOD) or all-ones (WRAP); tc pulses.
- ONESHOT step: done=1 → hold. Otherwise ±1 (up with count ≥ limit: hold); when new count reaches T (or is already there), done=1 and tc pulses once.
- MOD, limit=0: count stays 0, tc every step. MOD up, count > limit (limit lowered): next step wraps to 0.
- mode/dir/limit changes take effect on next step; no state flush.

## Timing
- Reset values: count=0, tc=0, done=0, prescaler=0; applied immediately on rst low, independent of clk.
- count changes on the edge where step/clr/load sampled; latency 1 clk.
- tc high exactly the cycle after the wrapping (or done-setting) edge; never two consecutive cycles unless PRESCALE=1 and consecutive wraps (MOD limit=0).
- done rises same edge as tc in ONESHOT; cleared only by clr, load, or reset.
- clr/load concurrent with a wrap: no tc.
- Reset deassertion: first step possible on the edge after rst high; prescaler starts from 0.

## Structure
- Shared package/include: mode encodings (MODE_WRAP=0, MODE_MOD=1, MODE_ONESHOT=2), DIR_UP/DIR_DOWN.
- One sub-module: prog_prescaler (parameter PRESCALE; ports clk, rst, en, sclr, tick), degenerating to tick=1 when PRESCALE=1.
- Core: next-count mux + terminal compare in one always block; single sequential block for count/tc/done.

## Test plan
- Reset & WRAP up, WIDTH=8, PRESCALE=1, en=1: count 0,1,…,255,0; tc high one cycle after 255→0; rst low mid-run at count 100 → count 0 immediately.
- MOD down, limit=5, load_val=2: after load, steps give 1,0,5,4; tc pulse after 0→5.
- ONESHOT up, limit=3, PRESCALE=4: count increments every 4 enabled clks, 0→1→2→3; done=1 and single tc at 3; further 20 clks hold 3; clr → 0, done=0.
- Priority: clr, load(0x42), step asserted same cycle → count 0; load+step → 0x42; en dropped mid-prescale for 3 clks → step delayed exactly 3 clks.
- MOD edge: count=10, limit lowered to 4, up → next step 0 with tc; limit=0 → count stays 0, tc every cycle.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: counting modes and direction.
package prog_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_MOD     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prog_prescaler.sv
// Step prescaler: tick once every PRESCALE enabled cycles; constant tick when PRESCALE is 1.
module prog_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sclr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, en, sclr};
            assign tick = 1'b1;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            logic [PW-1:0] cnt;

            assign tick = (cnt == PW'(PRESCALE - 1));

            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt <= '0;
                end else if (sclr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= tick ? '0 : cnt + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaled stepping and WRAP / MOD / ONESHOT modes.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    logic             tick;
    logic             step;
    logic             oneshot;
    logic [WIDTH-1:0] wrap_top;
    logic [WIDTH-1:0] reach;
    logic [WIDTH-1:0] stepped;
    logic             at_term;
    logic [WIDTH-1:0] next_count;
    logic             next_tc;
    logic             next_done;

    prog_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sclr (clr | load),
        .tick (tick)
    );

    assign step = en & tick;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_count = count;
        next_tc    = 1'b0;
        next_done  = done;

        oneshot  = (mode == MODE_ONESHOT);
        // Upper bound when counting up, and reload value when wrapping down.
        wrap_top = (mode == MODE_MOD || oneshot) ? limit : '1;
        reach    = (dir == DIR_DOWN) ? '0 : wrap_top;
        at_term  = (dir == DIR_DOWN) ? (count == '0) : (count >= wrap_top);
        stepped  = (dir == DIR_DOWN) ? count - WIDTH'(1) : count + WIDTH'(1);

        if (clr) begin
            next_count = '0;
            next_done  = 1'b0;
        end else if (load) begin
            next_count = load_val;
            next_done  = 1'b0;
        end else if (step) begin
            if (oneshot) begin
                if (!done) begin
                    if (at_term) begin
                        next_done = 1'b1;
                        next_tc   = 1'b1;
                    end else begin
                        next_count = stepped;
                        if (stepped == reach) begin
                            next_done = 1'b1;
                            next_tc   = 1'b1;
                        end
                    end
                end
            end else if (at_term) begin
                next_count = (dir == DIR_DOWN) ? wrap_top : '0;
                next_tc    = 1'b1;
            end else begin
                next_count = stepped;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= next_tc;
            done  <= next_done;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench: instance A (PRESCALE=1) for WRAP/MOD/priority, instance B (PRESCALE=4) for ONESHOT/prescale.
module tb_prog_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       en_a = 1'b0, clr_a = 1'b0, load_a = 1'b0, dir_a = 1'b0;
    logic [1:0] mode_a = 2'd0;
    logic [7:0] load_val_a = '0, limit_a = '0, count_a;
    logic       tc_a, done_a;

    logic       en_b = 1'b0, clr_b = 1'b0, load_b = 1'b0, dir_b = 1'b0;
    logic [1:0] mode_b = 2'd0;
    logic [7:0] load_val_b = '0, limit_b = '0, count_b;
    logic       tc_b, done_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(8), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .clr(clr_a), .load(load_a),
        .load_val(load_val_a), .dir(dir_a), .mode(mode_a), .limit(limit_a),
        .count(count_a), .tc(tc_a), .done(done_a)
    );

    prog_counter #(.WIDTH(8), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .load(load_b),
        .load_val(load_val_b), .dir(dir_b), .mode(mode_b), .limit(limit_b),
        .count(count_b), .tc(tc_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle outputs away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int md_cnt[4] = '{1, 0, 5, 4};
    int md_tc[4]  = '{0, 0, 1, 0};
    int en_pat[7] = '{1, 1, 0, 0, 0, 1, 1};

    initial begin
        // Reset state
        #12;
        check("rst_count", 32'(count_a), 0);
        check("rst_tc", 32'(tc_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_count_b", 32'(count_b), 0);

        // WRAP up, full lap
        @(negedge clk);
        rst  = 1'b1;
        en_a = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            cyc();
            check("wrap_count", 32'(count_a), 32'(i % 256));
            check("wrap_tc", 32'(tc_a), (i == 256) ? 1 : 0);
        end
        cyc();
        check("wrap_count_after", 32'(count_a), 1);
        check("wrap_tc_single", 32'(tc_a), 0);

        // Asynchronous reset mid-run
        for (int i = 0; i < 99; i++) cyc();
        check("pre_rst_count", 32'(count_a), 100);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_count", 32'(count_a), 0);
        en_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Modulo mode, counting down from a loaded value
        mode_a = 2'd1; dir_a = 1'b1; limit_a = 8'd5; load_val_a = 8'd2; load_a = 1'b1;
        cyc();
        check("mod_load", 32'(count_a), 2);
        load_a = 1'b0; en_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("mod_down_count", 32'(count_a), 32'(md_cnt[i]));
            check("mod_down_tc", 32'(tc_a), 32'(md_tc[i]));
        end

        // Priority: clr > load > step
        mode_a = 2'd0; dir_a = 1'b0;
        clr_a = 1'b1; load_a = 1'b1; load_val_a = 8'h42;
        cyc();
        check("prio_clr", 32'(count_a), 0);
        clr_a = 1'b0;
        cyc();
        check("prio_load", 32'(count_a), 32'h42);
        load_val_a = 8'hff;
        cyc();
        check("load_ff", 32'(count_a), 32'hff);
        load_a = 1'b0; clr_a = 1'b1;
        cyc();
        check("clr_on_wrap_count", 32'(count_a), 0);
        check("clr_on_wrap_tc", 32'(tc_a), 0);
        clr_a = 1'b0;

        // Modulo mode with limit lowered below count, then limit zero
        mode_a = 2'd1; limit_a = 8'd20; load_val_a = 8'd10; load_a = 1'b1;
        cyc();
        check("mod_load10", 32'(count_a), 10);
        load_a = 1'b0; limit_a = 8'd4;
        cyc();
        check("mod_lowered_count", 32'(count_a), 0);
        check("mod_lowered_tc", 32'(tc_a), 1);
        limit_a = 8'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mod_lim0_count", 32'(count_a), 0);
            check("mod_lim0_tc", 32'(tc_a), 1);
        end
        en_a = 1'b0;

        // ONESHOT up, limit 3, stepping every 4 enabled clocks
        mode_b = 2'd2; limit_b = 8'd3; dir_b = 1'b0; en_b = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            cyc();
            check("os_count", 32'(count_b), 32'(e / 4));
            check("os_tc", 32'(tc_b), (e == 12) ? 1 : 0);
            check("os_done", 32'(done_b), (e == 12) ? 1 : 0);
        end
        for (int e = 0; e < 20; e++) begin
            cyc();
            check("os_hold_count", 32'(count_b), 3);
            check("os_hold_tc", 32'(tc_b), 0);
            check("os_hold_done", 32'(done_b), 1);
        end
        clr_b = 1'b1;
        cyc();
        check("os_clr_count", 32'(count_b), 0);
        check("os_clr_done", 32'(done_b), 0);
        clr_b = 1'b0;

        // en dropped mid-prescale delays the step by the same number of clocks
        mode_b = 2'd0;
        for (int e = 0; e < 7; e++) begin
            en_b = en_pat[e][0];
            cyc();
            check("pre_gap_count", 32'(count_b), (e == 6) ? 1 : 0);
        end
        en_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
